param_deserializer: RTL and testbench
=====================================

// Module: param_deserializer
//
// PURPOSE
// Serial-to-parallel converter: assembles WIDTH-bit words from 1-bit samples qualified by write_in.
// Delivers each word to the downstream queue through a data_ready/ack_in handshake.
// Sits between the serial input stage and the queue, in the clock_100KHZ domain.
// Compared with the fixed 8-bit deserializer, it adds:
//  - parametrised width and bit order
//  - an output holding register, so the next word is received while the queue drains
//  - a mid-frame inactivity timeout.
//
// PARAMETERS
// WIDTH      8  bits per word; legal range 2..32
// MSB_FIRST  1  1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0]
// TIMEOUT    0  idle cycles allowed mid-frame before the partial word is discarded; 0 = timeout disabled
//
// PORTS
// clock_100KHZ  in   1                    system clock; all logic on the rising edge
// reset         in   1                    asynchronous, active-high
// data_in       in   1                    serial bit, sampled when a bit is accepted
// write_in      in   1                    bit strobe
// ack_in        in   1                    queue has consumed data_out
// status_out    out  1                    1 = ready to accept bits
// data_out      out  WIDTH                holding register, i.e. the last delivered word
// data_ready    out  1                    data_out holds an unacknowledged word
// timeout_err   out  1                    one-cycle pulse: partial word discarded
// bit_count     out  $clog2(WIDTH+1)      bits in the current partial word
// state_out     out  2                    FSM state: IDLE=0, SHIFT=1, STALL=2
//
// BEHAVIOUR
// - Reset (asynchronous): all outputs are 0, state is IDLE, and the shift register and idle counter are cleared.
//   - status_out rises on the first clock edge after reset deasserts.
//   - A reset asserted mid-frame or in STALL discards everything.
// - All outputs are registered.
// - Bit accept: a bit is accepted on an edge where write_in=1 and status_out=1.
//   - MSB_FIRST=1: shift = {shift[WIDTH-2:0], data_in}.
//   - MSB_FIRST=0: shift = {data_in, shift[WIDTH-1:1]}.
//   - bit_count increments by 1 per accepted bit.
// - FSM:
//   - IDLE: when a bit is accepted, go to SHIFT (bit_count=1).
//   - SHIFT: an accepted bit that brings the count to WIDTH completes the word.
//     - If data_ready=0, or ack_in=1 on that same edge:
//       - data_out is loaded with the completed word (including the current bit) and data_ready=1.
//       - bit_count returns to 0 and the FSM goes to IDLE.
//       - Latency: data_ready is high the cycle after the last bit's edge.
//     - Otherwise: the FSM goes to STALL and status_out=0. The word is held in the shift register and bit_count=WIDTH.
//   - STALL: write_in is ignored.
//     - On an ack_in edge: data_out loads the shift register and data_ready stays 1.
//     - On that edge bit_count returns to 0, status_out becomes 1, and the FSM goes to IDLE.
// - Ack rule: ack_in while data_ready=1 clears data_ready on that edge, unless a new word is loaded on the same edge.
//   - If a new word is loaded on the same edge, data_ready stays 1 with the new data.
//   - ack_in while data_ready=0 is ignored.
// - data_out is stable from the edge data_ready rises until the acknowledging edge.
// - Timeout (TIMEOUT>0): in SHIFT, an idle counter increments on each edge with no accepted bit and clears on an accepted bit.
//   - When the counter reaches TIMEOUT: shift register, bit_count and idle counter clear.
//   - On that edge timeout_err=1 for one cycle and the FSM goes to IDLE.
//   - data_out and data_ready are unaffected.
//   - A bit accepted on the expiry edge wins: no timeout occurs.
// - The idle counter does not run in IDLE or STALL.
// - Counters are sized exactly and never wrap; bit_count never exceeds WIDTH.
//
// TESTING
// 1. WIDTH=8, MSB_FIRST=1: send 1,0,1,1,0,0,1,0 with no ack.
//    -> data_out=8'hB2, data_ready=1 one cycle after the 8th bit, state=IDLE, bit_count=0.
// 2. MSB_FIRST=0: same bit sequence.
//    -> data_out=8'h4D.
// 3. Word A pending (no ack): send 8 more bits of 8'h3C.
//    -> state=STALL, status_out=0, extra write_in ignored.
//    Then pulse ack_in -> data_out=8'h3C, data_ready=1, status_out=1.
// 4. Last bit and ack_in on the same edge with data_ready=1.
//    -> data_out updates to the new word, data_ready stays 1, no STALL.
// 5. TIMEOUT=4: send 3 bits, then 4 idle cycles.
//    -> timeout_err pulses once, bit_count=0.
//    Then 8 bits of 8'hA5 -> data_out=8'hA5.
// 6. Reset asserted after 5 bits with data_ready=1.
//    -> all outputs 0 immediately.
//    -> status_out=1 one edge after release.

Source files
------------

// File: rtl/param_deserializer.sv
// Serial-to-parallel converter with a parametrised word width, selectable bit order,
// an output holding register with a ready/ack handshake, and a mid-frame idle timeout.
module param_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 0
) (
    input  logic                       clock_100KHZ,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    output logic                       status_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_ready,
    output logic                       timeout_err,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic [1:0]                 state_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             rdy_q, rdy_d;
    logic             terr_q, terr_d;
    logic             status_q, status_d;
    logic             accept;
    logic             load;
    logic             last_bit;
    logic             expire;

    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] s,
        input logic             b
    );
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {s[WIDTH-2:0], b};
        end else begin
            r = {b, s[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign accept   = write_in && status_q;
    assign last_bit = (count_q == CW'(WIDTH - 1));
    assign expire   = (TIMEOUT > 0) && (idle_q == IW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        count_d = count_q;
        idle_d  = idle_q;
        rdy_d   = rdy_q;
        terr_d  = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                idle_d = '0;
                if (accept) begin
                    shift_d = shift_in(shift_q, data_in);
                    count_d = CW'(1);
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (accept) begin
                    idle_d  = '0;
                    shift_d = shift_in(shift_q, data_in);
                    if (!last_bit) begin
                        count_d = count_q + CW'(1);
                    end else if (!rdy_q || ack_in) begin
                        load    = 1'b1;
                        dout_d  = shift_d;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        // Holding register still owned by the queue: park the word.
                        count_d = CW'(WIDTH);
                        state_d = STALL;
                    end
                end else if (TIMEOUT > 0) begin
                    if (expire) begin
                        shift_d = '0;
                        count_d = '0;
                        idle_d  = '0;
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end

            STALL: begin
                if (ack_in) begin
                    load    = 1'b1;
                    dout_d  = shift_q;
                    count_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            rdy_d = 1'b1;
        end else if (ack_in && rdy_q) begin
            rdy_d = 1'b0;
        end

        status_d = (state_d != STALL);
    end

    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            dout_q   <= '0;
            count_q  <= '0;
            idle_q   <= '0;
            rdy_q    <= 1'b0;
            terr_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            count_q  <= count_d;
            idle_q   <= idle_d;
            rdy_q    <= rdy_d;
            terr_q   <= terr_d;
            status_q <= status_d;
        end
    end

    assign status_out  = status_q;
    assign data_out    = dout_q;
    assign data_ready  = rdy_q;
    assign timeout_err = terr_q;
    assign bit_count   = count_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_param_deserializer.sv
// Bench for param_deserializer: two instances (MSB-first with timeout, LSB-first without)
// driven in lockstep and compared every cycle against a bit-list reference model.
module tb_param_deserializer;

    logic clk;
    logic reset;
    logic data_in;
    logic write_in;
    logic ack_in;

    logic       stat_a, rdy_a, terr_a;
    logic [7:0] dout_a;
    logic [3:0] bc_a;
    logic [1:0] st_a;
    logic       stat_b, rdy_b, terr_b;
    logic [7:0] dout_b;
    logic [3:0] bc_b;
    logic [1:0] st_b;

    int total = 0;
    int bad = 0;

    param_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT(4)) dut_a (
        .clock_100KHZ(clk),
        .reset(reset),
        .data_in(data_in),
        .write_in(write_in),
        .ack_in(ack_in),
        .status_out(stat_a),
        .data_out(dout_a),
        .data_ready(rdy_a),
        .timeout_err(terr_a),
        .bit_count(bc_a),
        .state_out(st_a)
    );

    param_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT(0)) dut_b (
        .clock_100KHZ(clk),
        .reset(reset),
        .data_in(data_in),
        .write_in(write_in),
        .ack_in(ack_in),
        .status_out(stat_b),
        .data_out(dout_b),
        .data_ready(rdy_b),
        .timeout_err(terr_b),
        .bit_count(bc_b),
        .state_out(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: received bits kept as a list, word built arithmetically.
    bit        m_up   [2];
    bit        m_pend [2];
    bit [7:0]  m_pw   [2];
    bit [7:0]  m_out  [2];
    bit        m_rdy  [2];
    bit        m_terr [2];
    int        m_idle [2];
    int        m_nb   [2];
    bit [31:0] m_buf  [2];

    function automatic bit msb_first(int d);
        return d == 0;
    endfunction

    function automatic int tmo(int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic bit [7:0] pack(int d);
        int w = 0;
        for (int i = 0; i < 8; i++) begin
            if (msb_first(d)) w = w * 2 + int'(m_buf[d][i]);
            else              w = w + (int'(m_buf[d][i]) << i);
        end
        return 8'(w);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_up[d] = 0; m_pend[d] = 0; m_pw[d] = 0;
            m_out[d] = 0; m_rdy[d] = 0; m_terr[d] = 0;
            m_idle[d] = 0; m_nb[d] = 0; m_buf[d] = 0;
        end
    endtask

    task automatic model_step(int d, bit w, bit b, bit a);
        bit ok_in;
        bit loaded;
        ok_in = m_up[d] && !m_pend[d] && w;
        loaded = 0;
        m_terr[d] = 0;
        if (m_pend[d]) begin
            if (a) begin
                m_out[d] = m_pw[d];
                m_pend[d] = 0;
                loaded = 1;
            end
        end else if (ok_in) begin
            m_buf[d][m_nb[d]] = b;
            m_nb[d]++;
            m_idle[d] = 0;
            if (m_nb[d] == 8) begin
                m_nb[d] = 0;
                if (!m_rdy[d] || a) begin
                    m_out[d] = pack(d);
                    loaded = 1;
                end else begin
                    m_pw[d] = pack(d);
                    m_pend[d] = 1;
                end
            end
        end else if (m_nb[d] > 0 && tmo(d) > 0) begin
            m_idle[d]++;
            if (m_idle[d] == tmo(d)) begin
                m_nb[d] = 0;
                m_idle[d] = 0;
                m_terr[d] = 1;
            end
        end
        if (loaded) m_rdy[d] = 1;
        else if (a) m_rdy[d] = 0;
        m_up[d] = 1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_dut(int d, logic s, logic [7:0] o, logic r,
                             logic t, logic [3:0] bc, logic [1:0] st);
        int e_st;
        int e_bc;
        e_st = m_pend[d] ? 2 : (m_nb[d] > 0 ? 1 : 0);
        e_bc = m_pend[d] ? 8 : m_nb[d];
        chk($sformatf("status%0d", d), 32'(s), 32'(m_up[d] && !m_pend[d]));
        chk($sformatf("data_out%0d", d), 32'(o), 32'(m_out[d]));
        chk($sformatf("data_ready%0d", d), 32'(r), 32'(m_rdy[d]));
        chk($sformatf("timeout_err%0d", d), 32'(t), 32'(m_terr[d]));
        chk($sformatf("bit_count%0d", d), 32'(bc), 32'(e_bc));
        chk($sformatf("state%0d", d), 32'(st), 32'(e_st));
    endtask

    task automatic check_all();
        check_dut(0, stat_a, dout_a, rdy_a, terr_a, bc_a, st_a);
        check_dut(1, stat_b, dout_b, rdy_b, terr_b, bc_b, st_b);
    endtask

    task automatic step(bit w, bit b, bit a);
        write_in = w;
        data_in  = b;
        ack_in   = a;
        @(posedge clk);
        if (!reset) begin
            for (int d = 0; d < 2; d++) model_step(d, w, b, a);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic send_byte(bit [7:0] v, bit ack_last);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, v[i], (i == 0) ? ack_last : 1'b0);
        end
    endtask

    // Called at a falling edge; asserts reset mid-cycle and checks the async clear.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_dout", 32'(dout_a), 32'h0);
        chk("rst_async_rdy", 32'(rdy_a), 32'h0);
        chk("rst_async_bc", 32'(bc_a), 32'h0);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("rst_status_up", 32'(stat_a), 32'h1);
    endtask

    int wprob;

    initial begin
        reset = 1'b1;
        write_in = 1'b0;
        data_in = 1'b0;
        ack_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_status", 32'(stat_a), 32'h0);
        chk("reset_state", 32'(st_a), 32'h0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("status_rise", 32'(stat_a), 32'h1);

        send_byte(8'hB2, 1'b0);
        chk("t1_dout", 32'(dout_a), 32'hB2);
        chk("t1_rdy", 32'(rdy_a), 32'h1);
        chk("t1_state", 32'(st_a), 32'h0);
        chk("t1_bc", 32'(bc_a), 32'h0);
        chk("t2_dout_lsb", 32'(dout_b), 32'h4D);

        send_byte(8'h3C, 1'b0);
        chk("t3_state", 32'(st_a), 32'h2);
        chk("t3_status", 32'(stat_a), 32'h0);
        chk("t3_bc", 32'(bc_a), 32'h8);
        chk("t3_hold", 32'(dout_a), 32'hB2);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_ignored_bc", 32'(bc_a), 32'h8);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_dout", 32'(dout_a), 32'h3C);
        chk("t3_rdy", 32'(rdy_a), 32'h1);
        chk("t3_status_back", 32'(stat_a), 32'h1);
        chk("t3_dout_lsb", 32'(dout_b), 32'h3C);

        send_byte(8'h5A, 1'b1);
        chk("t4_dout", 32'(dout_a), 32'h5A);
        chk("t4_rdy", 32'(rdy_a), 32'h1);
        chk("t4_state", 32'(st_a), 32'h0);

        step(1'b0, 1'b0, 1'b1);
        chk("t5_ack_clear", 32'(rdy_a), 32'h0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("t5_no_early_to", 32'(terr_a), 32'h0);
        chk("t5_bc_hold", 32'(bc_a), 32'h3);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_to_pulse", 32'(terr_a), 32'h1);
        chk("t5_to_bc", 32'(bc_a), 32'h0);
        chk("t5_to_state", 32'(st_a), 32'h0);
        chk("t5_no_to_b", 32'(bc_b), 32'h3);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_pulse_end", 32'(terr_a), 32'h0);
        send_byte(8'hA5, 1'b0);
        chk("t5_dout", 32'(dout_a), 32'hA5);

        repeat (5) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        chk("t6_bc5", 32'(bc_a), 32'h5);
        chk("t6_rdy", 32'(rdy_a), 32'h1);
        do_reset();

        wprob = 80;
        for (int n = 0; n < 4000; n++) begin
            if (n % 50 == 0) wprob = ($urandom_range(0, 2) == 0) ? 15 : 80;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < wprob),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < 30));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
